chasing_led_core: RTL and testbench
===================================

# chasing_led_core

MMIO slot core that drives a single lit LED along a `W`-bit LED bank, moving one position every programmable number of clock cycles. It wraps around at the ends or bounces between them. It sits in slot 5 of the vanilla MMIO subsystem, receives the slot bus from the MMIO controller, and its `led_output` feeds the board LED pins.

## Interface
- `W`, default 16: number of LEDs; legal range 2..32.
- `DEFAULT_PERIOD`, default 50_000_000: reset value of PERIOD, in clock cycles per step.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  one clock; reset is synchronous and active-low.
- `cs`  in  1  slot chip select.
- `read`  in  1  read strobe; qualified by `cs`.
- `write`  in  1  write strobe; qualified by `cs`.
- `addr`  in  5  register address.
- `wr_data`  in  32  write data.
- `rd_data`  out  32  read data.
- `led_output`  out  W  one-hot LED drive.

## Operation
Register map (`addr`):
- 0 CTRL (R/W):
  - bit0 `en`.
  - bit1 `bounce`: 1 = bounce, 0 = wrap.
  - bit2 `dir`: 0 = toward MSB, 1 = toward LSB.
  - Other bits read 0.
- 1 PERIOD (R/W, 32 bits): cycles per step. A value of 0 behaves as 1.
- 2 POS (R/W): bits[4:0] hold the current index.
  - A written value ≥ W loads W-1.
  - A write clears the tick counter.
- 3 STEPS (R/W, 32 bits): steps taken, wrapping at 2^32. Any write clears it to 0.
- `addr` 4..31: reads return 0; writes are ignored.

State machine:
- IDLE: `en`=0. Tick counter held at 0; position frozen.
- RUN: `en`=1. Tick counter counts 0..PERIOD-1. At terminal count it returns to 0 and issues a one-cycle `step`.
- Transitions: IDLE→RUN on a CTRL write with `en`=1. RUN→IDLE on a CTRL write with `en`=0, which also clears the counter.

On `step`:
- Wrap mode: pos moves ±1 mod W.
- Bounce mode: a step that would leave the range flips the internal direction and moves one position the other way, so W-1 → W-2 going up and 0 → 1 going down.
- STEPS increments on every step.

Direction handling:
- A CTRL write loads the internal direction from bit2.
- CTRL bit2 reads back the internal direction, including flips made by bounce.

Output and read path:
- `led_output` = registered one-hot of pos.
- `rd_data` is a combinational mux on `addr`, independent of `read`.

Reset values (all outputs and state):
- CTRL = 0, PERIOD = `DEFAULT_PERIOD`, pos = 0, STEPS = 0, counter = 0, state IDLE.
- `led_output` = 1 (LED 0 lit).

Simultaneous events:
- A POS write in the same cycle as `step`: the write wins and STEPS does not increment.
- A STEPS write in the same cycle as `step`: STEPS ends at 0.
- A PERIOD write restarts the counter at 0 in the following cycle, so no step is missed or doubled.
- A CTRL write that changes `bounce` mid-run takes effect on the next step.

## Timing
- Register writes take effect at the clock edge where `cs & write` is high. New values are readable the next cycle.
- From the CTRL write that sets `en`, the first `step` occurs PERIOD cycles later. `led_output` changes on the edge after `step`, so it updates every PERIOD cycles thereafter.
- A POS write updates `led_output` one cycle after the write edge.
- Reset asserted mid-run forces every reset value at the next edge, regardless of the bus.

## Structure
- Package `chasing_led_pkg` holds:
  - register address constants: `CTRL_REG`, `PERIOD_REG`, `POS_REG`, `STEPS_REG`;
  - CTRL bit indices;
  - the state enum `{IDLE, RUN}`.
- Slot constant `S5_CHASING` = 5 is added to `chu_io_map.svh`.
- One sub-module, `chasing_led_tick`, is natural: a 32-bit programmable prescaler with inputs `en`, `period`, `clr` and output `step`.
- `mmio_sys_vanilla` instantiates this core in slot 5. Its unused-slot generate starts at 6.

## Test plan
- Reset with W=16 → `led_output`=16'h0001; reads return CTRL=0, PERIOD=`DEFAULT_PERIOD`, POS=0, STEPS=0.
- PERIOD=4, CTRL=1 (wrap, up) → `led_output` shifts left every 4 cycles; after 16 steps it returns to 16'h0001 and STEPS=16.
- PERIOD=2, POS=15, CTRL=3 (bounce, up) → positions 14, 13 follow; CTRL readback bit2=1. From pos 0 the next position is 1 and bit2 reads 0.
- PERIOD=0, CTRL=1 → one step every cycle.
- POS write of 20 → POS reads 15 and `led_output`=16'h8000. A POS write coinciding with `step` → written value held, STEPS unchanged.
- Running at PERIOD=8, assert reset for 1 cycle at counter=5 → all reset values, state IDLE, no further steps until a CTRL write with `en`=1.

Source files
------------

// File: rtl/chasing_led_pkg.sv
// chasing_led_pkg: register map, CTRL bit positions and FSM state encoding for the chasing LED core.
package chasing_led_pkg;
  localparam logic [4:0] CTRL_REG   = 5'd0;
  localparam logic [4:0] PERIOD_REG = 5'd1;
  localparam logic [4:0] POS_REG    = 5'd2;
  localparam logic [4:0] STEPS_REG  = 5'd3;
  localparam int CTRL_EN     = 0;
  localparam int CTRL_BOUNCE = 1;
  localparam int CTRL_DIR    = 2;
  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;
endpackage

// File: rtl/chasing_led_tick.sv
// chasing_led_tick: 32-bit programmable prescaler; step pulses once every period cycles (0 acts as 1).
module chasing_led_tick (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        clr,
  input  logic [31:0] period,
  output logic        step
);
  logic [31:0] cnt_q, cnt_d, last;
  always_comb begin
    last  = (period == 32'd0) ? 32'd0 : period - 32'd1;
    step  = en && (cnt_q >= last);
    cnt_d = (!en || clr || step) ? 32'd0 : cnt_q + 32'd1;
  end
  always_ff @(posedge clk) begin
    if (!reset) cnt_q <= 32'd0;
    else        cnt_q <= cnt_d;
  end
endmodule

// File: rtl/chasing_led_core.sv
// chasing_led_core: MMIO slot core moving a single lit LED along a W-bit bank, wrapping or bouncing.
module chasing_led_core
  import chasing_led_pkg::*;
#(
  parameter int          W              = 16,
  parameter int unsigned DEFAULT_PERIOD = 50_000_000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cs,
  input  logic          read,
  input  logic          write,
  input  logic [4:0]    addr,
  input  logic [31:0]   wr_data,
  output logic [31:0]   rd_data,
  output logic [W-1:0]  led_output
);
  localparam logic [4:0] LAST = 5'(W - 1);
  state_t        state_q, state_d;
  logic          bounce_q, bounce_d, dir_q, dir_d;
  logic [31:0]   period_q, period_d, steps_q, steps_d;
  logic [4:0]    pos_q, pos_d, step_pos;
  logic [W-1:0]  led_q;
  logic          wr_ctrl, wr_period, wr_pos, wr_steps, step, moved, at_top, at_bot, step_dir;
  logic          unused_read;
  assign unused_read = read;
  assign wr_ctrl   = cs && write && addr == CTRL_REG;
  assign wr_period = cs && write && addr == PERIOD_REG;
  assign wr_pos    = cs && write && addr == POS_REG;
  assign wr_steps  = cs && write && addr == STEPS_REG;
  chasing_led_tick u_tick (
    .clk    (clk),
    .reset  (reset),
    .en     (state_q == RUN),
    .clr    (wr_period || wr_pos || (wr_ctrl && !wr_data[CTRL_EN])),
    .period (period_q),
    .step   (step)
  );
  always_comb begin
    at_top   = pos_q == LAST;
    at_bot   = pos_q == 5'd0;
    moved    = step && !wr_pos;
    step_pos = dir_q ? (at_bot ? (bounce_q ? 5'd1 : LAST) : pos_q - 5'd1)
                     : (at_top ? (bounce_q ? LAST - 5'd1 : 5'd0) : pos_q + 5'd1);
    step_dir = (bounce_q && (dir_q ? at_bot : at_top)) ? !dir_q : dir_q;
    pos_d    = wr_pos ? ((wr_data >= 32'(W)) ? LAST : wr_data[4:0]) : moved ? step_pos : pos_q;
    dir_d    = wr_ctrl ? wr_data[CTRL_DIR] : moved ? step_dir : dir_q;
    bounce_d = wr_ctrl ? wr_data[CTRL_BOUNCE] : bounce_q;
    state_d  = wr_ctrl ? (wr_data[CTRL_EN] ? RUN : IDLE) : state_q;
    period_d = wr_period ? wr_data : period_q;
    steps_d  = wr_steps ? 32'd0 : moved ? steps_q + 32'd1 : steps_q;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      bounce_q <= 1'b0;
      dir_q    <= 1'b0;
      period_q <= 32'(DEFAULT_PERIOD);
      steps_q  <= 32'd0;
      pos_q    <= 5'd0;
      led_q    <= W'(1);
    end else begin
      state_q  <= state_d;
      bounce_q <= bounce_d;
      dir_q    <= dir_d;
      period_q <= period_d;
      steps_q  <= steps_d;
      pos_q    <= pos_d;
      led_q    <= W'(1) << pos_q;
    end
  end
  assign led_output = led_q;
  always_comb
    rd_data = (addr == CTRL_REG)   ? {29'd0, dir_q, bounce_q, state_q == RUN} :
              (addr == PERIOD_REG) ? period_q :
              (addr == POS_REG)    ? {27'd0, pos_q} :
              (addr == STEPS_REG)  ? steps_q : 32'd0;
endmodule

// File: tb/tb_chasing_led_core.sv
// tb_chasing_led_core: directed vector table plus multi-cycle sequences for chasing_led_core (W=16).
module tb_chasing_led_core;
  logic        clk = 1'b0, reset = 1'b0, cs = 1'b0, read = 1'b0, write = 1'b0;
  logic [4:0]  addr = 5'd0;
  logic [31:0] wr_data = 32'd0, rd_data;
  logic [15:0] led_output;
  int checks = 0, errors = 0;

  chasing_led_core #(.W(16), .DEFAULT_PERIOD(50_000_000)) dut (
    .clk(clk), .reset(reset), .cs(cs), .read(read), .write(write),
    .addr(addr), .wr_data(wr_data), .rd_data(rd_data), .led_output(led_output)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        c;
    logic [4:0]  a;
    logic [31:0] d;
    logic [4:0]  ra;
    logic [31:0] er;
    logic [15:0] el;
  } vec_t;
  vec_t v[10];

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_reg(input string name, input logic [4:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    check(name, rd_data, exp);
  endtask

  task automatic wr(input logic c, input logic [4:0] a, input logic [31:0] d);
    cs = c; write = 1'b1; addr = a; wr_data = d;
    @(posedge clk);
    #1;
    cs = 1'b0; write = 1'b0;
  endtask

  initial begin
    v[0] = '{1'b1, 5'd2, 32'd3,          5'd2, 32'd3,  16'h0008};
    v[1] = '{1'b0, 5'd2, 32'd7,          5'd2, 32'd3,  16'h0008};
    v[2] = '{1'b1, 5'd2, 32'd20,         5'd2, 32'd15, 16'h8000};
    v[3] = '{1'b1, 5'd2, 32'd32,         5'd2, 32'd15, 16'h8000};
    v[4] = '{1'b1, 5'd2, 32'd0,          5'd2, 32'd0,  16'h0001};
    v[5] = '{1'b1, 5'd1, 32'd4,          5'd1, 32'd4,  16'h0001};
    v[6] = '{1'b1, 5'd0, 32'd6,          5'd0, 32'd6,  16'h0001};
    v[7] = '{1'b1, 5'd0, 32'hFFFF_FFF8,  5'd0, 32'd0,  16'h0001};
    v[8] = '{1'b1, 5'd9, 32'd5,          5'd9, 32'd0,  16'h0001};
    v[9] = '{1'b1, 5'd3, 32'd123,        5'd3, 32'd0,  16'h0001};

    tick(2);
    reset = 1'b1;
    check("reset_led", 32'(led_output), 32'h1);
    chk_reg("reset_ctrl", 5'd0, 32'd0);
    chk_reg("reset_period", 5'd1, 32'd50_000_000);
    chk_reg("reset_pos", 5'd2, 32'd0);
    chk_reg("reset_steps", 5'd3, 32'd0);

    for (int i = 0; i < 10; i++) begin
      wr(v[i].c, v[i].a, v[i].d);
      tick(1);
      chk_reg($sformatf("vec%0d_rd", i), v[i].ra, v[i].er);
      check($sformatf("vec%0d_led", i), 32'(led_output), 32'(v[i].el));
    end

    // wrap, up, PERIOD=4: position k reached 4k cycles after enabling
    wr(1'b1, 5'd1, 32'd4);
    wr(1'b1, 5'd2, 32'd0);
    wr(1'b1, 5'd3, 32'd0);
    wr(1'b1, 5'd0, 32'd1);
    for (int k = 1; k <= 16; k++) begin
      tick(4);
      chk_reg($sformatf("wrap_pos%0d", k), 5'd2, 32'(k % 16));
      check($sformatf("wrap_led%0d", k), 32'(led_output), 32'(1) << ((k - 1) % 16));
    end
    chk_reg("wrap_steps", 5'd3, 32'd16);
    tick(1);
    check("wrap_led_home", 32'(led_output), 32'h1);

    // bounce at the top end
    wr(1'b1, 5'd0, 32'd0);
    wr(1'b1, 5'd1, 32'd2);
    wr(1'b1, 5'd2, 32'd15);
    wr(1'b1, 5'd0, 32'd3);
    tick(2);
    chk_reg("bounce_top_pos1", 5'd2, 32'd14);
    chk_reg("bounce_top_ctrl", 5'd0, 32'd7);
    tick(2);
    chk_reg("bounce_top_pos2", 5'd2, 32'd13);
    // bounce at the bottom end
    wr(1'b1, 5'd0, 32'd0);
    wr(1'b1, 5'd2, 32'd1);
    wr(1'b1, 5'd0, 32'd7);
    tick(2);
    chk_reg("bounce_bot_pos0", 5'd2, 32'd0);
    chk_reg("bounce_bot_ctrl0", 5'd0, 32'd7);
    tick(2);
    chk_reg("bounce_bot_pos1", 5'd2, 32'd1);
    chk_reg("bounce_bot_ctrl1", 5'd0, 32'd3);

    // PERIOD=0 steps every cycle
    wr(1'b1, 5'd0, 32'd0);
    wr(1'b1, 5'd1, 32'd0);
    wr(1'b1, 5'd2, 32'd0);
    wr(1'b1, 5'd3, 32'd0);
    wr(1'b1, 5'd0, 32'd1);
    for (int k = 1; k <= 3; k++) begin
      tick(1);
      chk_reg($sformatf("p0_pos%0d", k), 5'd2, 32'(k));
    end
    chk_reg("p0_steps", 5'd3, 32'd3);

    // POS and STEPS writes landing on a step
    wr(1'b1, 5'd0, 32'd0);
    wr(1'b1, 5'd1, 32'd4);
    wr(1'b1, 5'd2, 32'd0);
    wr(1'b1, 5'd3, 32'd0);
    wr(1'b1, 5'd0, 32'd1);
    tick(3);
    wr(1'b1, 5'd2, 32'd9);
    chk_reg("poscoll_pos", 5'd2, 32'd9);
    chk_reg("poscoll_steps", 5'd3, 32'd0);
    tick(4);
    chk_reg("poscoll_next_pos", 5'd2, 32'd10);
    chk_reg("poscoll_next_steps", 5'd3, 32'd1);
    tick(3);
    wr(1'b1, 5'd3, 32'd77);
    chk_reg("stepscoll_steps", 5'd3, 32'd0);
    chk_reg("stepscoll_pos", 5'd2, 32'd11);

    // reset mid-run at counter=5
    wr(1'b1, 5'd0, 32'd0);
    wr(1'b1, 5'd1, 32'd8);
    wr(1'b1, 5'd2, 32'd0);
    wr(1'b1, 5'd0, 32'd1);
    tick(5);
    reset = 1'b0;
    cs = 1'b1; write = 1'b1; addr = 5'd2; wr_data = 32'd6;
    tick(1);
    cs = 1'b0; write = 1'b0;
    reset = 1'b1;
    check("mid_reset_led", 32'(led_output), 32'h1);
    chk_reg("mid_reset_ctrl", 5'd0, 32'd0);
    chk_reg("mid_reset_period", 5'd1, 32'd50_000_000);
    chk_reg("mid_reset_pos", 5'd2, 32'd0);
    tick(20);
    chk_reg("idle_pos", 5'd2, 32'd0);
    chk_reg("idle_steps", 5'd3, 32'd0);
    wr(1'b1, 5'd1, 32'd2);
    wr(1'b1, 5'd0, 32'd1);
    tick(2);
    chk_reg("restart_pos", 5'd2, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
